mem_arbiter: RTL and testbench

//  Two-port arbiter/sequencer in front of the 512x32 RAM. Port 0 is the CPU datapath MAR/MDR path; port 1 is the loader/IO path.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter/sequencer in front of a level-sensitive RAM (SETUP/ACCESS/HOLD strobe framing).
// Define MEM_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module mem_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 1,
    parameter int WR_WAIT = 1
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              grant_id
);
    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_WAIT - 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, RESP} state_t;

    state_t            state_reg;
    logic              we_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              mask_valid_reg;
    logic              mask_id_reg;
    logic [1:0]        req_vec;
    logic [1:0]        elig;
    logic              win_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              last_access;

    assign req_vec     = {p1_req, p0_req};
    assign last_access = (state_reg == ACCESS) && (cnt_reg == '0);

    // Per-port request masking, ack pulse and read-data capture.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic              ack_reg;
            logic [DATA_W-1:0] rdata_reg;

            assign elig[gi] = req_vec[gi] & ~(mask_valid_reg & (mask_id_reg == 1'(gi)));

            always_ff @(posedge clock) begin
                if (clear) begin
                    ack_reg   <= 1'b0;
                    rdata_reg <= '0;
                end else begin
                    ack_reg <= (state_reg == HOLD) && (grant_id == 1'(gi));
                    if (last_access && !we_reg && (grant_id == 1'(gi)))
                        rdata_reg <= ram_rdata;
                end
            end
        end
    endgenerate

    assign p0_ack   = g_port[0].ack_reg;
    assign p1_ack   = g_port[1].ack_reg;
    assign p0_rdata = g_port[0].rdata_reg;
    assign p1_rdata = g_port[1].rdata_reg;

`ifdef MEM_ARB_FIXED_PRIO_EN
    assign win_id = ~elig[0];
`else
    logic last_reg;

    // Tie goes to the port not served last; pointer moves at grant time.
    assign win_id = (elig[0] & elig[1]) ? ~last_reg : elig[1];

    always_ff @(posedge clock) begin
        if (clear)
            last_reg <= 1'b1;
        else if ((state_reg == IDLE) && (|elig))
            last_reg <= win_id;
    end
`endif

    assign sel_we    = win_id ? p1_we    : p0_we;
    assign sel_addr  = win_id ? p1_addr  : p0_addr;
    assign sel_wdata = win_id ? p1_wdata : p0_wdata;

    // Address/data registers load only at grant, so they frame every strobe on both sides.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            cnt_reg        <= '0;
            mask_valid_reg <= 1'b0;
            mask_id_reg    <= 1'b0;
            ram_read       <= 1'b0;
            ram_write      <= 1'b0;
            ram_address    <= '0;
            ram_wdata      <= '0;
            busy           <= 1'b0;
            grant_id       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mask_valid_reg <= 1'b0;
                    if (|elig) begin
                        state_reg   <= SETUP;
                        busy        <= 1'b1;
                        grant_id    <= win_id;
                        we_reg      <= sel_we;
                        ram_address <= sel_addr;
                        ram_wdata   <= sel_wdata;
                    end
                end
                SETUP: begin
                    state_reg <= ACCESS;
                    cnt_reg   <= we_reg ? WR_LOAD : RD_LOAD;
                    ram_read  <= ~we_reg;
                    ram_write <= we_reg;
                end
                ACCESS: begin
                    if (cnt_reg == '0) begin
                        state_reg <= HOLD;
                        ram_read  <= 1'b0;
                        ram_write <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                HOLD: begin
                    state_reg <= RESP;
                end
                RESP: begin
                    state_reg      <= IDLE;
                    busy           <= 1'b0;
                    mask_valid_reg <= 1'b1;
                    mask_id_reg    <= grant_id;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    ram_read  <= 1'b0;
                    ram_write <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter: model of memory, arbitration rules and latency formulas.
module tb_mem_arbiter;
    localparam int AW  = 9;
    localparam int DW  = 32;
    localparam int RDW = 3;
    localparam int WRW = 1;

    logic          clock;
    logic          clear;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic          ram_read, ram_write;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          busy, grant_id;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
        .clock(clock), .clear(clear),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .grant_id(grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Behavioural RAM seen by the DUT (level-sensitive write sampled at the clock edge).
    logic [DW-1:0] ram [0:511];
    initial forever begin
        @(posedge clock);
        if (ram_write) ram[ram_address] = ram_wdata;
    end
    assign ram_rdata = ram_read ? ram[ram_address] : 32'h0BAD_F00D;

    typedef struct {
        bit            port;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] rdata;
        int            ack_cyc;
    } exp_t;
    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } stb_t;

    exp_t          sb[$];
    stb_t          stq[$];
    logic [DW-1:0] model_mem [0:511];
    logic [DW-1:0] last_rd [2];
    bit            last_srv;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int model_txn(input bit p, input bit w, input logic [AW-1:0] a,
                                     input logic [DW-1:0] d, input int ack);
        exp_t e;
        stb_t s;
        s.we = w; s.addr = a; s.wdata = d;
        stq.push_back(s);
        if (w) model_mem[a] = d;
        else   last_rd[p] = model_mem[a];
        e.port = p; e.we = w; e.addr = a; e.rdata = last_rd[p]; e.ack_cyc = ack;
        sb.push_back(e);
        return ack;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 15));
        if ($urandom_range(0, 1) == 1) a = a | 9'h1F0;
        return a;
    endfunction

    // Ack monitor: pops the scoreboard whenever an ack appears.
    initial forever begin
        exp_t e;
        @(negedge clock);
        if (!clear && (p0_ack || p1_ack)) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'(1), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("ack_both", 64'(p0_ack && p1_ack), 64'(0));
                chk("ack_port", 64'(p1_ack), 64'(e.port));
                chk("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
                chk("grant_id", 64'(grant_id), 64'(e.port));
                chk("rdata", 64'(e.port ? p1_rdata : p0_rdata), 64'(e.rdata));
                $display("txn port=%0d %s addr=0x%03h rdata=0x%08h ack_cycle=%0d",
                         e.port, e.we ? "WR" : "RD", e.addr, e.port ? p1_rdata : p0_rdata, cyc);
            end
        end
    end

    // Strobe monitor: exclusivity, address/data on each strobe, strobe length.
    initial begin
        int   slen;
        stb_t sh;
        slen = 0;
        sh.we = 1'b0; sh.addr = '0; sh.wdata = '0;
        forever begin
            @(negedge clock);
            if (ram_read || ram_write) begin
                chk("strobe_excl", 64'(ram_read && ram_write), 64'(0));
                if (slen == 0) begin
                    if (stq.size() == 0) begin
                        chk("unexpected_strobe", 64'(1), 64'(0));
                    end else begin
                        sh = stq.pop_front();
                        chk("strobe_we", 64'(ram_write), 64'(sh.we));
                        chk("strobe_addr", 64'(ram_address), 64'(sh.addr));
                        if (sh.we) chk("strobe_wdata", 64'(ram_wdata), 64'(sh.wdata));
                    end
                end
                slen++;
            end else if (slen > 0) begin
                chk("strobe_len", 64'(slen), 64'(sh.we ? WRW : RDW));
                slen = 0;
            end
        end
    end

    // Address and write data must not move while a transfer is in flight.
    initial begin
        logic          pbusy;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pwd;
        pbusy = 1'b0; paddr = '0; pwd = '0;
        forever begin
            @(negedge clock);
            if (!clear && busy && pbusy) begin
                chk("addr_stable", 64'(ram_address), 64'(paddr));
                chk("wdata_stable", 64'(ram_wdata), 64'(pwd));
            end
            pbusy = busy; paddr = ram_address; pwd = ram_wdata;
        end
    end

    task automatic do_round(input bit u0, input bit u1, input bit w0, input bit w1,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            input bit scr, input logic [AW-1:0] scr_addr);
        int c, first, second, k;
        bit got0, got1;
        bit wv[2];
        logic [AW-1:0] av[2];
        logic [DW-1:0] dv[2];
        wv[0] = w0; wv[1] = w1; av[0] = a0; av[1] = a1; dv[0] = d0; dv[1] = d1;
        c = cyc;
        p0_we = w0; p0_addr = a0; p0_wdata = d0; p0_req = u0;
        p1_we = w1; p1_addr = a1; p1_wdata = d1; p1_req = u1;
        if (u0 && u1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            first = 0;
`else
            first = last_srv ? 0 : 1;
`endif
            second = 1 - first;
            k = model_txn(first[0], wv[first], av[first], dv[first], c + 3 + (wv[first] ? WRW : RDW));
            void'(model_txn(second[0], wv[second], av[second], dv[second],
                            k + 4 + (wv[second] ? WRW : RDW)));
            last_srv = second[0];
        end else begin
            first = u0 ? 0 : 1;
            void'(model_txn(first[0], wv[first], av[first], dv[first], c + 3 + (wv[first] ? WRW : RDW)));
            last_srv = first[0];
        end
        got0 = !u0; got1 = !u1;
        for (int i = 1; i <= 60 && !(got0 && got1); i++) begin
            @(negedge clock);
            if (p0_ack) begin got0 = 1'b1; p0_req = 1'b0; end
            if (p1_ack) begin got1 = 1'b1; p1_req = 1'b0; end
            if (scr && i == 2) begin
                if (u0) begin p0_addr = scr_addr; p0_we = ~p0_we; p0_wdata = ~p0_wdata; end
                else    begin p1_addr = scr_addr; p1_we = ~p1_we; p1_wdata = ~p1_wdata; end
            end
        end
        if (!(got0 && got1)) begin
            chk("round_timeout", 64'(0), 64'(1));
            p0_req = 1'b0; p1_req = 1'b0;
            sb.delete(); stq.delete();
        end
        repeat ($urandom_range(2, 4)) @(negedge clock);
    endtask

    // p1 keeps req high through its ack with new fields; the mask costs one IDLE cycle.
    task automatic do_b2b(input logic [AW-1:0] a1, input logic [DW-1:0] d2);
        int c, k, got;
        c = cyc;
        p1_we = 1'b0; p1_addr = a1; p1_wdata = 32'h5555_AAAA; p1_req = 1'b1;
        k = model_txn(1'b1, 1'b0, a1, 32'h5555_AAAA, c + 3 + RDW);
        void'(model_txn(1'b1, 1'b1, 9'h1FF, d2, k + 5 + WRW));
        got = 0;
        for (int i = 0; i < 60 && got < 2; i++) begin
            @(negedge clock);
            if (p1_ack) begin
                got++;
                if (got == 1) begin p1_we = 1'b1; p1_addr = 9'h1FF; p1_wdata = d2; end
                else p1_req = 1'b0;
            end
        end
        last_srv = 1'b1;
        if (got < 2) begin
            chk("b2b_timeout", 64'(got), 64'(2));
            p1_req = 1'b0;
            sb.delete(); stq.delete();
        end
        repeat ($urandom_range(2, 4)) @(negedge clock);
    endtask

    task automatic do_abort(input logic [AW-1:0] a, input logic [DW-1:0] d);
        stb_t s;
        p0_we = 1'b1; p0_addr = a; p0_wdata = d; p0_req = 1'b1;
        s.we = 1'b1; s.addr = a; s.wdata = d;
        stq.push_back(s);
        model_mem[a] = d;
        repeat (2) @(negedge clock);
        chk("abort_write_active", 64'(ram_write), 64'(1));
        clear = 1'b1; p0_req = 1'b0;
        @(negedge clock);
        chk("abort_ram_write", 64'(ram_write), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_ack", 64'(p0_ack), 64'(0));
        clear = 1'b0;
        last_rd[0] = '0; last_rd[1] = '0; last_srv = 1'b1;
        repeat (8) @(negedge clock);
        chk("abort_idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram[i]       = 32'hA500_0000 | 32'(i * 7);
            model_mem[i] = 32'hA500_0000 | 32'(i * 7);
        end
        last_rd[0] = '0; last_rd[1] = '0; last_srv = 1'b1;
        clear = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_ram_read", 64'(ram_read), 64'(0));
        chk("rst_ram_write", 64'(ram_write), 64'(0));
        chk("rst_ram_address", 64'(ram_address), 64'(0));
        chk("rst_ram_wdata", 64'(ram_wdata), 64'(0));
        chk("rst_p0_ack", 64'(p0_ack), 64'(0));
        chk("rst_p1_ack", 64'(p1_ack), 64'(0));
        chk("rst_p0_rdata", 64'(p0_rdata), 64'(0));
        chk("rst_p1_rdata", 64'(p1_rdata), 64'(0));
        clear = 1'b0;
        repeat (2) @(negedge clock);

        do_round(1, 0, 1, 0, 9'h005, 9'h000, 32'hDEAD_BEEF, 32'h0, 0, 9'h0);
        do_round(1, 0, 0, 0, 9'h005, 9'h000, 32'h0, 32'h0, 0, 9'h0);
        do_round(1, 1, 0, 0, 9'h1F0, 9'h00F, 32'h0, 32'h0, 0, 9'h0);
        do_round(1, 1, 0, 0, 9'h005, 9'h1F0, 32'h0, 32'h0, 0, 9'h0);
        do_b2b(9'h005, 32'h1234_5678);
        do_round(1, 0, 0, 0, 9'h010, 9'h000, 32'h0F0F_0F0F, 32'h0, 1, 9'h020);
        do_round(0, 1, 0, 0, 9'h000, 9'h1FF, 32'h0, 32'h0, 0, 9'h0);

        for (int r = 0; r < 40; r++) begin
            int mode;
            bit u0, u1;
            mode = $urandom_range(0, 2);
            u0 = (mode != 1);
            u1 = (mode != 0);
            do_round(u0, u1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                     rand_addr(), rand_addr(), $urandom, $urandom,
                     (mode != 2) && ($urandom_range(0, 1) == 1), rand_addr());
        end

        do_abort(9'h0AA, 32'hCAFE_F00D);
        do_round(1, 1, 0, 0, 9'h001, 9'h002, 32'h0, 32'h0, 0, 9'h0);

        repeat (5) @(negedge clock);
        chk("sb_drained", 64'(sb.size()), 64'(0));
        chk("strobes_drained", 64'(stq.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
